// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch stage.
//  - icode values of the Y86-64 ISA (IHALT..IPOPQ)
//  - status codes reported with each fetched instruction
//  - RNONE: register id meaning "no register"
//  - fetch FSM state encoding
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DONE   = 2'd2,
    S_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/y86_insn_len.sv
// Combinational instruction-length decoder.
//  icode     in  4  instruction class from byte 0
//  len       out 4  total instruction length in bytes (1 for unknown codes)
//  need_regs out 1  byte 1 is a register specifier byte
//  need_valc out 1  instruction carries an 8-byte little-endian constant
//  invalid   out 1  icode is not a defined Y86-64 instruction
module y86_insn_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       need_regs,
  output logic       need_valc,
  output logic       invalid
);

  always_comb begin
    len       = 4'd1;
    need_regs = 1'b0;
    need_valc = 1'b0;
    invalid   = 1'b0;
    case (icode)
      IHALT, INOP, IRET: len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        len       = 4'd2;
        need_regs = 1'b1;
      end
      IJXX, ICALL: begin
        len       = 4'd9;
        need_valc = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        len       = 4'd10;
        need_regs = 1'b1;
        need_valc = 1'b1;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 SEQ fetch stage. Holds the architectural PC, reads instruction bytes
// one per ack from a byte-wide memory and assembles the decoded fields.
//  clk, rst            clock, synchronous active-high reset
//  start               leaves IDLE and begins the first fetch
//  imem_req/addr       byte read request at pc + byte index
//  imem_ack/data/err   byte response (data/err qualified by ack)
//  pc_load, new_pc     downstream done; load next PC and fetch again
//  instr_valid         decoded fields below are valid and stable
//  icode/ifun/rA/rB    decoded instruction fields
//  valC, valP, pc      constant, next sequential PC, PC of this instruction
//  stat                AOK / HLT / ADR / INS
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  input  logic              imem_err,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] new_pc,
  output logic              instr_valid,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [ADDR_W-1:0] valC,
  output logic [ADDR_W-1:0] valP,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        stat
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] valp_q, valp_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d;
  logic [3:0]        rb_q, rb_d;
  logic [63:0]       const_q, const_d;
  logic [1:0]        stat_q, stat_d;

  // Byte 0 is decoded straight off the memory bus so a 1-byte instruction
  // (or an illegal opcode) can finish on the same ack.
  logic [3:0] dec_icode;
  logic [3:0] dec_len;
  logic       dec_regs;
  logic       dec_valc;
  logic       dec_invalid;
  logic [2:0] byte_k;
  logic       const_we;
  logic       const_clr;

  assign dec_icode = (idx_q == 4'd0) ? imem_data[7:4] : icode_q;

  y86_insn_len u_len (
    .icode     (dec_icode),
    .len       (dec_len),
    .need_regs (dec_regs),
    .need_valc (dec_valc),
    .invalid   (dec_invalid)
  );

  // Constant bytes start right after the opcode byte, or after the
  // register byte when there is one.
  assign byte_k = 3'(idx_q - (dec_regs ? 4'd2 : 4'd1));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    valp_d    = valp_q;
    stat_d    = stat_q;
    const_we  = 1'b0;
    const_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          idx_d     = 4'd0;
          ra_d      = RNONE;
          rb_d      = RNONE;
          const_clr = 1'b1;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            state_d = S_DONE;
            stat_d  = STAT_ADR;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd0) begin
              icode_d = imem_data[7:4];
              ifun_d  = imem_data[3:0];
            end
            if (dec_regs && idx_q == 4'd1) begin
              ra_d = imem_data[7:4];
              rb_d = imem_data[3:0];
            end
            const_we = dec_valc && (idx_q >= (dec_regs ? 4'd2 : 4'd1));
            if (dec_invalid) begin
              state_d = S_DONE;
              stat_d  = STAT_INS;
              valp_d  = pc_q + ADDR_W'(1);
            end else if (idx_q == dec_len - 4'd1) begin
              state_d = S_DONE;
              valp_d  = pc_q + ADDR_W'(dec_len);
              stat_d  = (dec_icode == IHALT) ? STAT_HLT : STAT_AOK;
            end
          end
        end
      end
      S_DONE: begin
        if (pc_load) begin
          if (stat_q == STAT_AOK) begin
            state_d   = S_FETCH;
            pc_d      = new_pc;
            idx_d     = 4'd0;
            ra_d      = RNONE;
            rb_d      = RNONE;
            const_clr = 1'b1;
          end else begin
            // Faulting instruction: freeze pc/stat for inspection until reset.
            state_d = S_HALTED;
          end
        end
      end
      default: ;
    endcase
  end

  // One write-enabled byte lane per constant byte.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_const_lane
      assign const_d[8*gi +: 8] = const_clr ? 8'h00 :
                                  (const_we && byte_k == 3'(gi)) ? imem_data :
                                  const_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      idx_q   <= 4'd0;
      icode_q <= IHALT;
      ifun_q  <= 4'd0;
      ra_q    <= RNONE;
      rb_q    <= RNONE;
      const_q <= 64'd0;
      valp_q  <= '0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      const_q <= const_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q + ADDR_W'(idx_q);
  assign instr_valid = (state_q == S_DONE);
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = ADDR_W'(const_q);
  assign valP        = valp_q;
  assign pc          = pc_q;
  assign stat        = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Bench for y86_fetch_unit: byte memory model with configurable wait states,
// directed table of instructions, hand sequences for multi-cycle corners,
// and randomized instructions checked against a reference decoder.
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_data = 8'h00;
  logic        imem_err = 1'b0;
  logic        pc_load = 1'b0;
  logic [63:0] new_pc = 64'h0;
  logic        instr_valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc;
  logic [1:0]  stat;

  y86_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .imem_err(imem_err),
    .pc_load(pc_load), .new_pc(new_pc),
    .instr_valid(instr_valid), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .pc(pc), .stat(stat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- memory model ----------------
  logic [7:0]  mem  [logic [63:0]];
  bit          errs [logic [63:0]];
  int          stall = 0;
  int          wait_cnt = 0;
  int          total_req = 0;
  int          stable_errs = 0;
  logic [63:0] ack_log [$];
  logic        pend_q = 1'b0;
  logic [63:0] pend_addr = 64'h0;
  int          req_base, log_base;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Response driven mid-cycle; junk is driven whenever it must be ignored.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt >= stall) begin
        imem_ack  = 1'b1;
        imem_data = rd(imem_addr);
        imem_err  = (errs.exists(imem_addr) != 0);
        wait_cnt  = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        imem_err  = 1'($urandom);
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      wait_cnt  = 0;
      imem_ack  = 1'($urandom);
      imem_data = 8'($urandom);
      imem_err  = 1'($urandom);
    end
  end

  always @(posedge clk) begin
    if (!rst && pend_q && imem_req && imem_addr !== pend_addr) stable_errs <= stable_errs + 1;
    pend_q    <= imem_req && !imem_ack && !rst;
    pend_addr <= imem_addr;
    if (imem_req && !rst) total_req <= total_req + 1;
    if (imem_req && imem_ack && !rst) ack_log.push_back(imem_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100 && !instr_valid; i++) tick();
    chk({tag, " valid"}, {63'd0, instr_valid}, 64'd1);
  endtask

  task automatic cmp_fields(input string tag, input logic [3:0] e_ic, input logic [3:0] e_fn,
                            input logic [3:0] e_ra, input logic [3:0] e_rb, input logic [63:0] e_vc,
                            input logic [63:0] e_vp, input logic [1:0] e_st, input logic [63:0] e_pc,
                            input bit full);
    $display("txn %s pc=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d",
             tag, pc, icode, ifun, rA, rB, valC, valP, stat);
    chk({tag, " stat"}, 64'(stat), 64'(e_st));
    chk({tag, " pc"}, pc, e_pc);
    if (full) begin
      chk({tag, " icode"}, 64'(icode), 64'(e_ic));
      chk({tag, " ifun"}, 64'(ifun), 64'(e_fn));
      chk({tag, " rA"}, 64'(rA), 64'(e_ra));
      chk({tag, " rB"}, 64'(rB), 64'(e_rb));
      chk({tag, " valC"}, valC, e_vc);
      chk({tag, " valP"}, valP, e_vp);
    end
  endtask

  task automatic chk_addrs(input string tag, input logic [63:0] a, input int n);
    bit ok;
    ok = 1'b1;
    chk({tag, " nreq"}, 64'(ack_log.size() - log_base), 64'(n));
    for (int i = 0; i < n && log_base + i < ack_log.size(); i++)
      if (ack_log[log_base + i] !== a + 64'(i)) ok = 1'b0;
    chk({tag, " addrs"}, {63'd0, ok}, 64'd1);
  endtask

  // Reset, then fetch a nop at 0 so the DUT sits in DONE with stat AOK.
  task automatic prelude();
    rst = 1'b1; start = 1'b0; pc_load = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mem.delete(); errs.delete();
    mem[64'h0] = 8'h10;
    stall = 0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("prelude");
    mem.delete();
  endtask

  task automatic fetch_at(input logic [63:0] a, input int st);
    stall    = st;
    req_base = total_req;
    log_base = ack_log.size();
    new_pc   = a;
    pc_load  = 1'b1; tick(); pc_load = 1'b0;
    wait_valid("fetch");
  endtask

  // ---------------- reference decoder ----------------
  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [1:0]  stat;
    int          nreq;
    bit          full;
  } exp_t;

  function automatic exp_t model(input logic [63:0] pc0);
    exp_t        e;
    logic [7:0]  b;
    logic [63:0] a;
    int          len;
    bit          regs;
    e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
    e.valc = 64'h0; e.valp = 64'h0; e.stat = 2'd0; e.nreq = 0; e.full = 1'b1;
    len = 1; regs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = pc0 + 64'(i);
      e.nreq = i + 1;
      if (errs.exists(a)) begin
        e.stat = 2'd2; e.full = 1'b0;
        return e;
      end
      b = rd(a);
      if (i == 0) begin
        e.icode = b[7:4]; e.ifun = b[3:0];
        case (b[7:4])
          4'h0, 4'h1, 4'h9:       begin len = 1;  regs = 1'b0; end
          4'h2, 4'h6, 4'hA, 4'hB: begin len = 2;  regs = 1'b1; end
          4'h7, 4'h8:             begin len = 9;  regs = 1'b0; end
          4'h3, 4'h4, 4'h5:       begin len = 10; regs = 1'b1; end
          default: begin
            e.stat = 2'd3; e.valp = pc0 + 64'd1;
            return e;
          end
        endcase
      end else if (regs && i == 1) begin
        e.ra = b[7:4]; e.rb = b[3:0];
      end else begin
        e.valc = e.valc | (64'(b) << (8 * (i - (regs ? 2 : 1))));
      end
      if (i == len - 1) begin
        e.valp = pc0 + 64'(len);
        e.stat = (e.icode == 4'h0) ? 2'd1 : 2'd0;
        return e;
      end
    end
    return e;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [63:0] pc;
    logic [79:0] bytes;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [1:0]  stat;
    int          nreq;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{64'h20, 80'h80_00_01_00_00_00_00_00_00_00, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 2'd0, 9};
    vt[1] = '{64'h40, 80'h20_30_00_00_00_00_00_00_00_00, 4'h2, 4'h0, 4'h3, 4'h0, 64'h0, 64'h42, 2'd0, 2};
    vt[2] = '{64'h60, 80'hC0_00_00_00_00_00_00_00_00_00, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61, 2'd3, 1};
    vt[3] = '{64'h80, 80'h00_00_00_00_00_00_00_00_00_00, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h81, 2'd1, 1};
    vt[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 80'h30_F4_11_22_33_44_55_66_77_88, 4'h3, 4'h0, 4'hF, 4'h4,
              64'h8877_6655_4433_2211, 64'h8, 2'd0, 10};
    vt[5] = '{64'h100, 80'h90_00_00_00_00_00_00_00_00_00, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 2'd0, 1};
    vt[6] = '{64'h200, 80'h73_EF_BE_AD_DE_00_00_00_00_00, 4'h7, 4'h3, 4'hF, 4'hF, 64'hDEAD_BEEF, 64'h209, 2'd0, 9};
    vt[7] = '{64'h300, 80'h61_23_00_00_00_00_00_00_00_00, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h302, 2'd0, 2};
    vt[8] = '{64'h400, 80'h50_15_10_00_00_00_00_00_00_00, 4'h5, 4'h0, 4'h1, 4'h5, 64'h10, 64'h40A, 2'd0, 10};

    // ---- reset / idle ----
    tick(); tick();
    rst = 1'b0;
    chk("rst pc", pc, 64'h0);
    chk("rst req", {63'd0, imem_req}, 64'd0);
    chk("rst valid", {63'd0, instr_valid}, 64'd0);
    chk("rst stat", 64'(stat), 64'd0);
    chk("rst icode", 64'(icode), 64'd0);
    chk("rst rA", 64'(rA), 64'hF);
    chk("rst rB", 64'(rB), 64'hF);
    chk("rst valC", valC, 64'd0);
    chk("rst valP", valP, 64'd0);
    req_base = total_req;
    new_pc = 64'h77; pc_load = 1'b1; tick(); pc_load = 1'b0;
    repeat (4) tick();
    chk("idle no req", 64'(total_req - req_base), 64'd0);
    chk("idle pc_load ignored", pc, 64'h0);

    // ---- irmovq at 0, zero-wait ----
    mem.delete(); errs.delete(); stall = 0;
    begin
      logic [79:0] ir;
      ir = 80'h30_F3_08_07_06_05_04_03_02_01;
      for (int i = 0; i < 10; i++) mem[64'(i)] = ir[79 - 8*i -: 8];
    end
    req_base = total_req; log_base = ack_log.size();
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("irmovq");
    chk("irmovq fetch cycles", 64'(total_req - req_base), 64'd10);
    chk_addrs("irmovq", 64'h0, 10);
    cmp_fields("irmovq", 4'h3, 4'h0, 4'hF, 4'h3, 64'h0102_0304_0506_0708, 64'd10, 2'd0, 64'h0, 1'b1);
    chk("irmovq done req low", {63'd0, imem_req}, 64'd0);

    // ---- call, then pc_load to its target ----
    prelude();
    for (int i = 0; i < 10; i++) mem[64'h20 + 64'(i)] = vt[0].bytes[79 - 8*i -: 8];
    fetch_at(64'h20, 0);
    cmp_fields("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 2'd0, 64'h20, 1'b1);
    mem[64'h100] = 8'h10;
    new_pc = 64'h100; pc_load = 1'b1; tick(); pc_load = 1'b0;
    chk("call next req", {63'd0, imem_req}, 64'd1);
    chk("call next addr", imem_addr, 64'h100);
    chk("call next valid", {63'd0, instr_valid}, 64'd0);
    wait_valid("call target");

    // ---- directed table ----
    for (int v = 0; v < 9; v++) begin
      if (!(instr_valid && stat == 2'd0)) prelude();
      mem.delete(); errs.delete();
      for (int i = 0; i < 10; i++) mem[vt[v].pc + 64'(i)] = vt[v].bytes[79 - 8*i -: 8];
      fetch_at(vt[v].pc, 0);
      cmp_fields($sformatf("vec%0d", v), vt[v].icode, vt[v].ifun, vt[v].ra, vt[v].rb,
                 vt[v].valc, vt[v].valp, vt[v].stat, vt[v].pc, 1'b1);
      chk_addrs($sformatf("vec%0d", v), vt[v].pc, vt[v].nreq);
      chk($sformatf("vec%0d req low", v), {63'd0, imem_req}, 64'd0);
    end

    // ---- stalled memory: ack every 3rd cycle ----
    prelude();
    mem[64'h40] = 8'h20; mem[64'h41] = 8'h30;
    fetch_at(64'h40, 2);
    cmp_fields("stall", 4'h2, 4'h0, 4'h3, 4'h0, 64'h0, 64'h42, 2'd0, 64'h40, 1'b1);
    chk("stall req cycles", 64'(total_req - req_base), 64'd6);

    // ---- address error on byte 4 of mrmovq, then HALTED ----
    prelude();
    for (int i = 0; i < 10; i++) mem[64'h500 + 64'(i)] = (i == 0) ? 8'h50 : (i == 1) ? 8'h15 : 8'h00;
    errs[64'h504] = 1'b1;
    fetch_at(64'h500, 0);
    cmp_fields("adr", 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 2'd2, 64'h500, 1'b0);
    chk_addrs("adr", 64'h500, 5);
    repeat (3) tick();
    chk("adr no more reqs", 64'(total_req - req_base), 64'd5);
    new_pc = 64'h999; pc_load = 1'b1; tick(); pc_load = 1'b0;
    chk("halted valid", {63'd0, instr_valid}, 64'd0);
    req_base = total_req;
    start = 1'b1; tick(); start = 1'b0;
    pc_load = 1'b1; tick(); pc_load = 1'b0;
    repeat (3) tick();
    chk("halted no req", 64'(total_req - req_base), 64'd0);
    chk("halted pc", pc, 64'h500);
    chk("halted stat", 64'(stat), 64'd2);
    chk("halted valid held", {63'd0, instr_valid}, 64'd0);

    // ---- reset during byte 5 of a 10-byte fetch ----
    prelude();
    for (int i = 0; i < 10; i++) mem[64'h700 + 64'(i)] = (i == 0) ? 8'h30 : 8'hA5;
    stall = 0;
    new_pc = 64'h700; pc_load = 1'b1; tick(); pc_load = 1'b0;
    for (int i = 0; i < 20 && imem_addr != 64'h705; i++) tick();
    chk("midrst at byte5", imem_addr, 64'h705);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst req", {63'd0, imem_req}, 64'd0);
    chk("midrst pc", pc, 64'h0);
    chk("midrst valid", {63'd0, instr_valid}, 64'd0);

    // ---- randomized instructions vs reference decoder ----
    for (int t = 0; t < 40; t++) begin
      logic [63:0] a;
      exp_t        e;
      int          st;
      if (!(instr_valid && stat == 2'd0)) prelude();
      a = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                                      : {$urandom, $urandom};
      mem.delete(); errs.delete();
      for (int i = 0; i < 10; i++) mem[a + 64'(i)] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) errs[a + 64'($urandom_range(0, 9))] = 1'b1;
      st = $urandom_range(0, 2);
      fetch_at(a, st);
      e = model(a);
      cmp_fields($sformatf("rand%0d", t), e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat, a, e.full);
      chk_addrs($sformatf("rand%0d", t), a, e.nreq);
    end

    chk("addr stable while unacked", 64'(stable_errs), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
